// File: rtl/pulse_bit_decoder_pkg.sv
// Shared pipeline types: control-path edge strobes, decoder state, timing defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_types;

  // Edge strobes from the control path; each field is a one-cycle pulse.
  typedef struct packed {
    logic rising;
    logic falling;
  } control_path_t;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } decoder_state_t;

  // Timing defaults shared with the clock-enable and count-enable stages.
  localparam int DEC_WORD_W       = 24;
  localparam int DEC_CNT_W        = 10;
  localparam int MIN_HIGH_TICKS   = 2;
  localparam int ONE_THRESH_TICKS = 6;
  localparam int LATCH_GAP_TICKS  = 500;

endpackage

// File: rtl/pulse_bit_decoder_if.sv
// Bundle between the count-enable stage, the bit decoder and the pixel pipeline.
// Latency: n/a (wires only).
// Backpressure: none; all signals are strobes or held values.
// Ports: i_control / i_count_enable flow into the decoder; o_* flow out of it.
interface pulse_bit_decoder_if
  import pipeline_types::*;
#(
  parameter int WORD_W = DEC_WORD_W
);

  control_path_t     i_control;
  logic              i_count_enable;
  logic              o_bit_valid;
  logic              o_bit;
  logic              o_word_valid;
  logic [WORD_W-1:0] o_word;
  logic              o_latch;
  logic              o_error;

  // Upstream driver / observer side.
  modport master (
    output i_control, i_count_enable,
    input  o_bit_valid, o_bit, o_word_valid, o_word, o_latch, o_error
  );

  // Decoder side.
  modport slave (
    input  i_control, i_count_enable,
    output o_bit_valid, o_bit, o_word_valid, o_word, o_latch, o_error
  );

endinterface

// File: rtl/pulse_bit_decoder_bit_shifter.sv
// MSB-first word assembler: shifts decoded bits into the LSB, counts them, emits full words.
// Latency: word_valid/word register one cycle after the shift_en that completes the word.
// Backpressure: none; a shift is always accepted.
// Ports: i_clk, i_reset_n; shift_en/shift_bit/clear in; bit_cnt, word_valid, word out.
module bit_shifter
  import pipeline_types::*;
#(
  parameter int WORD_W = DEC_WORD_W,
  parameter int BC_W   = $clog2(DEC_WORD_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              shift_en,
  input  logic              shift_bit,
  input  logic              clear,
  output logic [BC_W-1:0]   bit_cnt,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_nxt;

  assign shift_nxt = {shift_q[WORD_W-2:0], shift_bit};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_q <= shift_nxt;
        if (bit_cnt == LAST_BIT) begin
          // Word complete: publish it and hold it until the next full word.
          word       <= shift_nxt;
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_bit_decoder.sv
// Pulse-width bit decoder: times high pulses in ticks, decodes 0/1, assembles words, detects latch gap.
// Latency: every output pulse is registered, appearing one cycle after the triggering edge/tick.
// Backpressure: none; edges and ticks are consumed every cycle.
// Ports: i_clk, i_reset_n; bus (slave) carries i_control, i_count_enable in and o_* results out.
module pulse_bit_decoder
  import pipeline_types::*;
#(
  parameter int WORD_W      = DEC_WORD_W,
  parameter int CNT_W       = DEC_CNT_W,
  parameter int MIN_HIGH    = MIN_HIGH_TICKS,
  parameter int ONE_THRESH  = ONE_THRESH_TICKS,
  parameter int LATCH_TICKS = LATCH_GAP_TICKS
) (
  input logic               i_clk,
  input logic               i_reset_n,
  pulse_bit_decoder_if.slave bus
);

  localparam int              BC_W       = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(ONE_THRESH);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_TICKS - 1);

  decoder_state_t   state;
  logic [CNT_W-1:0] tick_cnt;
  logic [BC_W-1:0]  bit_cnt;

  logic illegal;
  logic rise_only;
  logic fall_only;
  logic tick_ok;
  logic bit_val;
  logic decode_fire;
  logic glitch_fire;
  logic latch_fire;

  always_comb begin
    illegal     = bus.i_control.rising & bus.i_control.falling;
    rise_only   = bus.i_control.rising & ~bus.i_control.falling;
    fall_only   = bus.i_control.falling & ~bus.i_control.rising;
    // Any edge in the same cycle swallows the tick.
    tick_ok     = bus.i_count_enable & ~bus.i_control.rising & ~bus.i_control.falling;
    bit_val     = (tick_cnt >= ONE_C);
    decode_fire = (state == HIGH) & fall_only & (tick_cnt >= MIN_C);
    glitch_fire = (state == HIGH) & fall_only & (tick_cnt < MIN_C);
    // Fires on the tick that would make the low count reach the gap length.
    latch_fire  = (state == LOW) & tick_ok & (tick_cnt == LATCH_LAST);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bus.o_bit_valid <= 1'b0;
      bus.o_bit       <= 1'b0;
      bus.o_latch     <= 1'b0;
      bus.o_error     <= 1'b0;
    end else begin
      bus.o_bit_valid <= decode_fire;
      bus.o_bit       <= decode_fire & bit_val;
      bus.o_latch     <= latch_fire;
      bus.o_error     <= illegal | glitch_fire | (latch_fire & (bit_cnt != '0));

      case (state)
        IDLE: begin
          if (rise_only) begin
            state    <= HIGH;
            tick_cnt <= '0;
          end
        end
        HIGH: begin
          if (fall_only) begin
            state    <= LOW;
            tick_cnt <= '0;
          end else if (tick_ok && (tick_cnt != CNT_MAX)) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        LOW: begin
          if (rise_only) begin
            state    <= HIGH;
            tick_cnt <= '0;
          end else if (latch_fire) begin
            state    <= IDLE;
            tick_cnt <= '0;
          end else if (tick_ok) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  bit_shifter #(
    .WORD_W (WORD_W),
    .BC_W   (BC_W)
  ) u_bit_shifter (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .shift_en   (decode_fire),
    .shift_bit  (bit_val),
    .clear      (latch_fire),
    .bit_cnt    (bit_cnt),
    .word_valid (bus.o_word_valid),
    .word       (bus.o_word)
  );

endmodule

// File: tb/tb_pulse_bit_decoder.sv
// Self-checking bench for pulse_bit_decoder: vector table, directed corner sequences, random vs model.
// Latency: outputs sampled 1 time unit after the clock edge that registers each input cycle.
// Backpressure: n/a.
module tb_pulse_bit_decoder;
  import pipeline_types::*;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  pulse_bit_decoder_if #(.WORD_W(24)) bus ();

  pulse_bit_decoder #(
    .WORD_W(24), .CNT_W(10), .MIN_HIGH(2), .ONE_THRESH(6), .LATCH_TICKS(500)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: mode 0 idle, 1 line high, 2 line low.
  bit          model_on = 1'b0;
  int          m_mode;
  int          m_hi;
  int          m_lo;
  bit          m_bits[$];
  logic [23:0] m_word;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hi = 0; m_lo = 0; m_bits.delete(); m_word = '0;
  endtask

  // Spec-level behaviour: unbounded counts, a bit queue, words built arithmetically.
  task automatic model_step(input logic r, input logic f, input logic c,
                            output logic [3:0] ev, output logic eb);
    logic bv, wv, lt, er;
    int w;
    bv = 0; wv = 0; lt = 0; er = 0; eb = 0;
    if (r && f) er = 1;
    else if (m_mode == 0) begin
      if (r) begin m_mode = 1; m_hi = 0; end
    end else if (m_mode == 1) begin
      if (f) begin
        if (m_hi < 2) er = 1;
        else begin
          bv = 1; eb = (m_hi >= 6);
          m_bits.push_back(eb);
          if (m_bits.size() == 24) begin
            w = 0;
            foreach (m_bits[i]) w = w * 2 + int'(m_bits[i]);
            m_word = 24'(w); wv = 1; m_bits.delete();
          end
        end
        m_mode = 2; m_lo = 0;
      end else if (c && !r) m_hi++;
    end else begin
      if (r) begin m_mode = 1; m_hi = 0; end
      else if (c && !f) begin
        m_lo++;
        if (m_lo == 500) begin
          lt = 1;
          if (m_bits.size() != 0) er = 1;
          m_bits.delete(); m_mode = 0;
        end
      end
    end
    ev = {bv, wv, lt, er};
  endtask

  task automatic step(input logic r, input logic f, input logic c);
    logic [3:0] ev;
    logic eb;
    bus.i_control.rising = r; bus.i_control.falling = f; bus.i_count_enable = c;
    @(posedge i_clk); #1;
    if (model_on) begin
      model_step(r, f, c, ev, eb);
      chk("rnd_flags", {60'd0, bus.o_bit_valid, bus.o_word_valid, bus.o_latch, bus.o_error}, {60'd0, ev});
      if (ev[3]) chk("rnd_bit", {63'd0, bus.o_bit}, {63'd0, eb});
      chk("rnd_word", {40'd0, bus.o_word}, {40'd0, m_word});
    end
  endtask

  task automatic rst_dut();
    bus.i_control = '0; bus.i_count_enable = 1'b0;
    i_reset_n = 1'b0;
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    model_reset();
  endtask

  // Rise, `ticks` ticks, fall (outputs captured), then 2 low ticks.
  task automatic send_pulse(input int ticks, output logic bv, output logic b,
                            output logic er, output logic wv);
    step(1, 0, 0);
    for (int t = 0; t < ticks; t++) begin step(0, 0, 0); step(0, 0, 1); end
    step(0, 1, 0);
    bv = bus.o_bit_valid; b = bus.o_bit; er = bus.o_error; wv = bus.o_word_valid;
    for (int t = 0; t < 2; t++) begin step(0, 0, 0); step(0, 0, 1); end
  endtask

  task automatic send_bits(input logic [23:0] val, input int hi, input int lo,
                           output int bad, output int wvc, output logic lw);
    logic bv, b, er, wv;
    bad = 0; wvc = 0; lw = 0;
    for (int i = hi; i >= lo; i--) begin
      send_pulse(val[i] ? 8 : 3, bv, b, er, wv);
      if (!bv || b !== val[i] || er) bad++;
      if (wv) wvc++;
      lw = wv;
    end
  endtask

  task automatic gap(input int n, output int lts, output int ers, output int both);
    lts = 0; ers = 0; both = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1);
      if (bus.o_latch) lts++;
      if (bus.o_error) ers++;
      if (bus.o_latch && bus.o_error) both++;
    end
  endtask

  typedef struct {
    string nm;
    int    ticks;
    logic  bv;
    logic  b;
    logic  er;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bv, b, er, wv, lw;
    int bad, wvc, lts, ers, both, h, l, k;

    tbl[0] = '{"bit0_4t",   4, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{"bit1_8t",   8, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{"thr_6t",    6, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{"thr_5t",    5, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{"glitch_1t", 1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{"min_2t",    2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{"glitch_0t", 0, 1'b0, 1'b0, 1'b1};

    bus.i_control = '0; bus.i_count_enable = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_outputs", {35'd0, bus.o_bit_valid, bus.o_bit, bus.o_word_valid, bus.o_latch,
                          bus.o_error, bus.o_word}, 64'd0);
    i_reset_n = 1'b1;

    foreach (tbl[i]) begin
      send_pulse(tbl[i].ticks, bv, b, er, wv);
      chk(tbl[i].nm, {61'd0, bv, b & bv, er}, {61'd0, tbl[i].bv, tbl[i].b, tbl[i].er});
    end

    // Illegal edge pair while HIGH must keep state and tick count (3 + 4 ticks -> 1).
    rst_dut();
    step(1, 1, 0);
    chk("illegal_idle_err", {63'd0, bus.o_error}, 64'd1);
    step(1, 0, 0);
    for (int t = 0; t < 3; t++) step(0, 0, 1);
    step(1, 1, 1);
    chk("illegal_high_err", {62'd0, bus.o_error, bus.o_bit_valid}, {62'd0, 2'b10});
    for (int t = 0; t < 4; t++) step(0, 0, 1);
    step(0, 1, 0);
    chk("illegal_kept_state", {62'd0, bus.o_bit_valid, bus.o_bit}, {62'd0, 2'b11});

    rst_dut();
    send_bits(24'hA5C30F, 23, 0, bad, wvc, lw);
    chk("w1_bits", 64'(bad), 64'd0);
    chk("w1_wv_once", 64'(wvc), 64'd1);
    chk("w1_wv_last", {63'd0, lw}, 64'd1);
    chk("w1_word", {40'd0, bus.o_word}, {40'd0, 24'hA5C30F});
    send_bits(24'h3C3C3C, 23, 1, bad, wvc, lw);
    chk("hold_no_wv", 64'(wvc), 64'd0);
    chk("hold_word", {40'd0, bus.o_word}, {40'd0, 24'hA5C30F});
    send_bits(24'h3C3C3C, 0, 0, bad, wvc, lw);
    chk("w2_wv", {63'd0, lw}, 64'd1);
    chk("w2_word", {40'd0, bus.o_word}, {40'd0, 24'h3C3C3C});

    // Two low ticks already counted after the last fall; 497 more stays short.
    gap(497, lts, ers, both);
    chk("gap_499_no_latch", 64'(lts), 64'd0);
    gap(1, lts, ers, both);
    chk("gap_500_latch", {32'(lts), 32'(ers)}, {32'd1, 32'd0});
    gap(5, lts, ers, both);
    chk("idle_ticks_ignored", 64'(lts + ers), 64'd0);

    send_bits(24'h0003FF, 9, 0, bad, wvc, lw);
    chk("p10_bits", 64'(bad + wvc), 64'd0);
    gap(498, lts, ers, both);
    chk("p10_latch_err", {16'(lts), 16'(ers), 32'(both)}, {16'd1, 16'd1, 32'd1});
    send_bits(24'h123456, 23, 0, bad, wvc, lw);
    chk("w3_after_latch", {32'(bad), 31'(wvc), lw}, {32'd0, 31'd1, 1'b1});
    chk("w3_word", {40'd0, bus.o_word}, {40'd0, 24'h123456});

    // Asynchronous reset while HIGH mid-word.
    send_bits(24'hF00000, 23, 19, bad, wvc, lw);
    step(1, 0, 0);
    for (int t = 0; t < 3; t++) step(0, 0, 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {35'd0, bus.o_bit_valid, bus.o_bit, bus.o_word_valid, bus.o_latch,
                                bus.o_error, bus.o_word}, 64'd0);
    #1 i_reset_n = 1'b1;
    bus.i_control = '0;
    send_bits(24'h5A3CF0, 23, 0, bad, wvc, lw);
    chk("w4_after_reset", {32'(bad), 31'(wvc), lw}, {32'd0, 31'd1, 1'b1});
    chk("w4_word", {40'd0, bus.o_word}, {40'd0, 24'h5A3CF0});

    // Randomized traffic against the reference model.
    rst_dut();
    model_on = 1'b1;
    for (int p = 0; p < 160; p++) begin
      h = (p == 40 || p == 120) ? 1030 : $urandom_range(0, 12);
      step(1, 0, 1'($urandom_range(0, 1)));
      for (int t = 0; t < h; t++) begin
        repeat ($urandom_range(0, 2)) step(0, 0, 0);
        k = $urandom_range(0, 31);
        if (k == 0) step(1, 1, 1'($urandom_range(0, 1)));
        else if (k == 1) step(1, 0, 1);
        else step(0, 0, 1);
      end
      step(0, 1, 1'($urandom_range(0, 1)));
      l = (p % 25 == 12) ? 505 : $urandom_range(0, 6);
      for (int t = 0; t < l; t++) begin
        if ($urandom_range(0, 3) == 0) step(0, 0, 0);
        if ($urandom_range(0, 63) == 0) step(0, 1, 1);
        else step(0, 0, 1);
      end
    end
    model_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_bit_decoder.md
Name: pulse_bit_decoder

Overview:
- Consumes the edge strobes from the control path and the tick enable from the clock-enable stage.
- Measures each high pulse in ticks, classifies it as a 0 or 1 bit, and assembles the bits MSB-first into data words.
- Detects the long-low latch/reset gap on the line.
- Sits directly downstream of the count-enable stage; its word and latch outputs feed the pixel/colour pipeline.

Parameters:
- WORD_W, 24, bits per assembled word
- CNT_W, 10, tick counter width; the counter saturates at all-ones
- MIN_HIGH, 2, minimum high ticks for a valid bit; shorter pulses are glitches
- ONE_THRESH, 6, high ticks at or above this decode as 1, below decode as 0
- LATCH_TICKS, 500, consecutive low ticks that signal latch/reset

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_control  in  pipeline_types::control_path_t  edge strobes; uses .rising and .falling, each a one-cycle pulse
- i_count_enable  in  1  one-cycle tick pulse from the count-enable stage
- o_bit_valid  out  1  one-cycle pulse when a bit is decoded
- o_bit  out  1  decoded bit value; meaningful only with o_bit_valid
- o_word_valid  out  1  one-cycle pulse when WORD_W bits have been assembled
- o_word  out  WORD_W  assembled word; held stable until the next o_word_valid
- o_latch  out  1  one-cycle pulse when the latch gap is detected
- o_error  out  1  one-cycle pulse on a glitch, an illegal edge pair, or a partial word at latch

Behaviour:
- Reset is asynchronous and active-low: one clock i_clk, reset i_reset_n.
- Reset values: state=IDLE, all counters 0, shift register 0. All outputs are 0, including o_word.
- All outputs are registered; every pulse appears the cycle after the triggering input.
- States: IDLE, HIGH, LOW.
  - IDLE: rising -> HIGH with tick_cnt cleared. Ticks and falling edges are ignored.
  - HIGH: on i_count_enable, tick_cnt increments (saturating).
    - On falling with tick_cnt < MIN_HIGH: pulse o_error, drop the bit, go to LOW.
    - On falling otherwise: o_bit = (tick_cnt >= ONE_THRESH), pulse o_bit_valid, shift the bit into the LSB, bit_cnt++, go to LOW with tick_cnt cleared.
  - LOW: on i_count_enable, tick_cnt increments.
    - rising -> HIGH with tick_cnt cleared.
    - When tick_cnt reaches LATCH_TICKS: pulse o_latch; if bit_cnt != 0 also pulse o_error; clear bit_cnt and the shift register; go to IDLE.
- Word completion: when the decoded bit makes bit_cnt == WORD_W, o_word is loaded with the full shift value and o_word_valid pulses in the same cycle as o_bit_valid. bit_cnt then returns to 0.
- Tick timing: the enable stage restarts its divider on every rising edge, so the first tick arrives DIVISOR cycles after the rising edge. tick_cnt therefore equals the number of whole tick periods the line was high.
- Simultaneous edges: rising and falling together is illegal. Pulse o_error, ignore both edges, keep the current state.
- A tick coinciding with an edge in the same cycle: the edge wins and the tick is not counted.
- Saturation: a high pulse that saturates tick_cnt still decodes as 1 on falling.
- Reset mid-word: the partial word is discarded with no error pulse.

Decomposition:
- pipeline_types holds control_path_t (rising, falling) and a new enum decoder_state_t {IDLE, HIGH, LOW}.
- Defaults for MIN_HIGH, ONE_THRESH and LATCH_TICKS go in pipeline_types as named constants shared with the timing stages.
- One natural sub-module is bit_shifter: a WORD_W shift register with bit counter, clear and word-valid generation. The FSM and tick counter stay in the top.

Test Plan:
- Bit 0: rising, 4 ticks, falling -> o_bit_valid=1 and o_bit=0 one cycle after the falling edge, no error.
- Bit 1: rising, 8 ticks, falling -> o_bit=1. Then exactly 6 ticks -> 1 and exactly 5 ticks -> 0, proving the threshold boundary.
- Full word: drive 24 bits encoding 0xA5C30F -> a single o_word_valid pulse coincident with the 24th o_bit_valid and o_word=0xA5C30F. o_word then holds through the next 23 bits.
- Latch: 24 bits followed by 500 low ticks -> o_latch pulses once with no error. Repeat with 10 bits then the gap -> o_latch and o_error together, and the next word starts at bit_cnt 0.
- Glitch and illegal input: a 1-tick high pulse -> o_error with no o_bit_valid. Rising and falling in the same cycle -> o_error and the state is unchanged.
- Reset: assert i_reset_n low mid-word while HIGH -> all outputs 0 asynchronously. After release, a fresh 24-bit word decodes correctly.
